// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: pops words from a registered-output FIFO and presents
// them as a valid/ready stream. A 2-entry buffer plus one read credit covers
// the FIFO's 1-cycle read latency, so one word per cycle is sustained.
//
// Ports:
//   clk         system clock, rising edge
//   srst        synchronous active-high reset (overrides flush)
//   flush       drop buffered and in-flight words
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after a pop
//   fifo_rd_en  pop request to FIFO (combinational)
//   m_valid     stream word valid (registered)
//   m_ready     consumer accepts word
//   m_data      stream data (registered, holds until accepted)
//   xfer_count  number of accepted words, wraps
module fifo_stream_adapter #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    localparam int unsigned OCC_W = 2;
    localparam int unsigned LVL_W = 3;

    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 pop;
    logic                 arrival;
    logic [LVL_W-1:0]     level;

    // Words committed to this stage: buffered plus the one being read.
    assign level   = LVL_W'(occ_q) + LVL_W'(inflight_q);
    assign pop     = valid_q && m_ready;
    assign arrival = inflight_q && !flush;

    // Only pop when a slot is guaranteed free by the time the word lands.
    assign fifo_rd_en = !srst && !flush && !fifo_empty
                        && ((level < LVL_W'(2)) || pop);

    // Buffer bookkeeping: head is the presented word, tail the next one.
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_rd_en;
        cnt_d      = cnt_q + CNT_WIDTH'(pop);

        if (flush) begin
            occ_d = '0;
        end else begin
            case ({pop, arrival})
                2'b01: begin
                    if (occ_q == OCC_W'(0)) begin
                        head_d = fifo_dout;
                    end else begin
                        tail_d = fifo_dout;
                    end
                    occ_d = occ_q + OCC_W'(1);
                end
                2'b10: begin
                    if (occ_q == OCC_W'(2)) begin
                        head_d = tail_q;
                    end
                    occ_d = occ_q - OCC_W'(1);
                end
                2'b11: begin
                    if (occ_q == OCC_W'(2)) begin
                        head_d = tail_q;
                        tail_d = fifo_dout;
                    end else begin
                        head_d = fifo_dout;
                    end
                end
                default: ;
            endcase
        end

        valid_d = (occ_d != OCC_W'(0));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // The credit scheme must never let a landing word find the buffer full.
    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (level <= LVL_W'(2));
            assert (!(arrival && !pop && occ_q == OCC_W'(2)));
        end
    end

    assign m_valid    = valid_q;
    assign m_data     = head_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: a queue-based FIFO model feeds the DUT; every
// word leaving the FIFO is logged, and a monitor checks the stream against
// that log, dropping logged words on flush/reset.
module tb_fifo_stream_adapter;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             srst;
    logic             flush;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] xfer_count;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] taken_log[$];
    int               rd_idx   = 0;
    int               acc_cnt  = 0;
    int               checks   = 0;
    int               failures = 0;

    fifo_stream_adapter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
        .clk        (clk),
        .srst       (srst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Called at a negedge: advance one clock and apply the FIFO model's pop.
    task automatic tick();
        logic do_pop;
        do_pop = fifo_rd_en && !fifo_empty;
        chk("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
        @(posedge clk);
        #1;
        if (do_pop) begin
            fifo_dout = fifo_q.pop_front();
            taken_log.push_back(fifo_dout);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic step();
        @(negedge clk);
        tick();
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && rd_idx == taken_log.size()) && n < budget) begin
            if (rnd) m_ready = 1'($urandom);
            else     m_ready = 1'b1;
            step();
            n++;
        end
        chk("drain_done", 32'(fifo_q.size() == 0 && rd_idx == taken_log.size()), 32'd1);
    endtask

    // Stream monitor: order, hold-under-stall, counter and occupancy bound.
    task automatic monitor();
        logic             prev_hold = 1'b0;
        logic [WIDTH-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (srst) begin
                rd_idx    = taken_log.size();
                acc_cnt   = 0;
                prev_hold = 1'b0;
            end else begin
                chk("xfer_count", 32'(xfer_count), 32'(CNT_W'(acc_cnt)));
                chk("words_held_le2", 32'((taken_log.size() - rd_idx) <= 2), 32'd1);
                if (prev_hold) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'(m_data), 32'(prev_data));
                end
                if (m_valid && m_ready) begin
                    if (rd_idx < taken_log.size())
                        chk("stream_data", 32'(m_data), 32'(taken_log[rd_idx]));
                    else
                        chk("stream_unexpected_word", 32'(m_valid), 32'd0);
                    rd_idx++;
                    acc_cnt++;
                end
                if (flush) rd_idx = taken_log.size();
                prev_hold = m_valid && !m_ready && !flush;
                prev_data = m_data;
            end
        end
    endtask

    initial begin
        int first, last, nval, rd_pulses, sent, n;
        bit found;

        srst = 1'b1; flush = 1'b0; m_ready = 1'b1;
        fifo_empty = 1'b1; fifo_dout = '0;
        push(9'h0A5);
        repeat (3) step();

        // Reset state and first-word latency
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_xfer", 32'(xfer_count), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        fork monitor(); join_none
        srst = 1'b0;
        @(negedge clk);
        chk("lat_rd_en_t", 32'(fifo_rd_en), 32'd1);
        chk("lat_valid_t", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_valid_t1", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_valid_t2", 32'(m_valid), 32'd1);
        chk("lat_data_t2", 32'(m_data), 32'h0A5);
        tick();
        @(negedge clk);
        chk("lat_xfer", 32'(xfer_count), 32'd1);
        chk("lat_valid_after", 32'(m_valid), 32'd0);
        tick();

        // Throughput: 16 words back to back
        for (int i = 1; i <= 16; i++) push(WIDTH'(i));
        first = -1; last = -1; nval = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                nval++;
            end
            tick();
        end
        chk("thru_count", 32'(nval), 32'd16);
        chk("thru_contiguous", 32'(last - first + 1), 32'd16);
        @(negedge clk);
        chk("thru_xfer", 32'(xfer_count), 32'd17);
        tick();

        // Backpressure: 10-cycle stall
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(WIDTH'(9'h100 + i));
        rd_pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_pulses++;
            if (m_valid) chk("bp_head", 32'(m_data), 32'h100);
            tick();
        end
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd2);
        @(negedge clk);
        chk("bp_valid_stalled", 32'(m_valid), 32'd1);
        tick();
        drain(1'b0, 40);
        @(negedge clk);
        chk("bp_xfer", 32'(xfer_count), 32'd25);
        tick();

        // Random traffic with random ready
        sent = 0; n = 0;
        while (sent < 500 && n < 5000) begin
            if ($urandom_range(1, 0) == 1) begin
                push(WIDTH'($urandom));
                sent++;
            end
            m_ready = 1'($urandom);
            step();
            n++;
        end
        chk("rand_sent", 32'(sent), 32'd500);
        drain(1'b1, 4000);
        @(negedge clk);
        chk("rand_xfer", 32'(xfer_count), 32'd525);
        chk("rand_delivered", 32'(rd_idx), 32'd525);
        tick();

        // Flush with a word in flight and a coincident pop
        m_ready = 1'b0;
        push(9'h055); push(9'h056); push(9'h057);
        step();
        step();
        flush = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("fl_valid", 32'(m_valid), 32'd1);
        chk("fl_head", 32'(m_data), 32'h055);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_valid_next", 32'(m_valid), 32'd0);
        chk("fl_data_kept", 32'(m_data), 32'h055);
        tick();
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_valid && !found) begin
                found = 1'b1;
                chk("fl_next_word", 32'(m_data), 32'h057);
            end
            tick();
        end
        chk("fl_found_next", 32'(found), 32'd1);
        @(negedge clk);
        chk("fl_xfer", 32'(xfer_count), 32'd527);
        tick();

        // Reset beats flush with a full buffer
        m_ready = 1'b0;
        push(9'h1AA); push(9'h1BB);
        repeat (4) step();
        @(negedge clk);
        chk("rp_full_valid", 32'(m_valid), 32'd1);
        chk("rp_full_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        srst = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("rp_rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
        tick();
        srst = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("rp_valid", 32'(m_valid), 32'd0);
        chk("rp_data", 32'(m_data), 32'd0);
        chk("rp_xfer", 32'(xfer_count), 32'd0);
        tick();

        // Normal operation after reset
        push(9'h1CC);
        drain(1'b0, 20);
        @(negedge clk);
        chk("post_rst_xfer", 32'(xfer_count), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Downstream stage of the single-clock registered-output FIFO.
- Pops words from the FIFO's rd_en/dout/empty interface and presents them as a valid/ready stream with stable data. Once m_valid is high, m_data holds until accepted.
- A 2-entry output buffer with read-credit tracking sustains 1 word/cycle with no loss or duplication across the FIFO's 1-cycle read latency.
- Sits between the FIFO and any stream consumer (UART TX, SPI master, DMA sink).

Parameters:
- WIDTH, 9, data word width; must match FIFO WIDTH.
- CNT_WIDTH, 16, width of accepted-word counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- srst  input  1  synchronous reset, active-high, sampled on rising clk
- flush  input  1  synchronous drop of buffered and in-flight words
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  WIDTH  FIFO registered read data, valid the cycle after a successful pop
- fifo_rd_en  output  1  pop request to FIFO
- m_valid  output  1  stream word valid (registered)
- m_ready  input  1  consumer accepts word
- m_data  output  WIDTH  stream data (registered)
- xfer_count  output  CNT_WIDTH  count of accepted words (debug)

Behaviour:
- Interface decision: one clock (clk); reset srst is synchronous and active-high.
- Reset (srst=1): m_valid=0, m_data=0, xfer_count=0, occupancy=0, inflight=0. fifo_rd_en=0 combinationally while srst=1. srst overrides flush.
- State:
  - occ: 0..2, number of buffered words.
  - inflight: 1 bit, set when the previous cycle issued a pop.
- pop = m_valid && m_ready.
- fifo_rd_en = !srst && !flush && !fifo_empty && ((occ + inflight) < 2 || pop).
  - This is the only combinational path from m_ready; none exists to m_valid or m_data.
- inflight <= fifo_rd_en every cycle.
- Arrival: when inflight=1 (and no flush), fifo_dout is captured this cycle.
- Buffer update, for the combinations of pop/arrival:
  - Arrival only: append to tail.
  - Pop only: shift head.
  - Both at occ=1: arrival becomes head.
  - Both at occ=2: tail moves to head and arrival becomes tail.
- m_valid = (occ != 0). m_data = head entry.
- Invariant: occ + inflight ≤ 2 at all times; never overflow. Overflow is an assertion failure.
- Ordering: words leave strictly in FIFO order.
- Latency:
  - fifo_empty falls at cycle t with occ=0 → fifo_rd_en=1 at t, data on fifo_dout at t+1, m_valid=1 at t+2.
  - Steady state with m_ready=1 and FIFO non-empty: one word per cycle, no bubbles.
- Backpressure: m_valid && !m_ready → m_data, m_valid unchanged. At most 2 buffered plus 0 in flight; fifo_rd_en stays 0 until pop.
- Empty FIFO: fifo_rd_en=0. Buffered words still drain normally.
- Flush (flush=1):
  - fifo_rd_en=0.
  - Next cycle occ=0, m_valid=0, inflight=0.
  - A word arriving in the flush cycle (inflight=1) is discarded.
  - A pop coincident with flush still counts in xfer_count.
  - m_data keeps its last value.
- xfer_count increments by 1 on each pop, wraps modulo 2^CNT_WIDTH. Cleared only by srst.
- Reset mid-transfer: all buffered/in-flight words are lost. FIFO reset is the system's responsibility.

Test Plan:
- Latency: preload FIFO with 0x0A5, m_ready=1, release srst at cycle 0 → fifo_rd_en=1 at cycle 1, m_valid=1 with m_data=0x0A5 at cycle 3, xfer_count=1 after accept.
- Throughput: FIFO holds 0x001..0x010, m_ready=1 constantly → 16 consecutive cycles of m_valid=1 with data 0x001..0x010 in order, xfer_count=16.
- Backpressure: FIFO holds 0x100..0x107, m_ready=0 for 10 cycles then 1 → m_data=0x100 stable throughout the stall. fifo_rd_en pulses exactly twice then stays 0. After release, all 8 words emerge in order with no duplicates.
- Random ready: 500 random words, m_ready random 50% → scoreboard matches exact order, occ+inflight never exceeds 2, xfer_count=500.
- Flush with in-flight word: occ=1 (0x055), fifo_rd_en issued in the previous cycle for 0x056, assert flush for 1 cycle → m_valid=0 next cycle. 0x056 never appears. The next FIFO word 0x057 is the next stream output.
- Reset priority: srst=1 and flush=1 with occ=2 → all outputs at reset values next cycle, xfer_count=0, fifo_rd_en=0 during reset.
